// File: rtl/ycr_wb_sram_slv.sv
// ycr_wb_sram_slv: Wishbone data-bus slave that serves one request at a time from a
// single-port synchronous SRAM macro. Optional range/alignment check: YCR_WB_SRAM_RANGE_CHK_EN.
`default_nettype none
`timescale 1ns/1ps

module ycr_wb_sram_slv #(
    parameter int AW        = 9,
    parameter int MEM_DEPTH = 512,
    parameter int RD_LAT    = 1
) (
    input  logic          wb_clk,
    input  logic          wb_rst_n,
    input  logic          wbd_stb_i,
    input  logic [31:0]   wbd_adr_i,
    input  logic          wbd_we_i,
    input  logic [31:0]   wbd_dat_i,
    input  logic [3:0]    wbd_sel_i,
    output logic [31:0]   wbd_dat_o,
    output logic          wbd_ack_o,
    output logic          wbd_err_o,
    output logic          mem_csb_o,
    output logic          mem_web_o,
    output logic [3:0]    mem_wmask_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_din_o,
    input  logic [31:0]   mem_dout_i
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_RD_WAIT = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t          r_state;
    logic [1:0]      r_cnt;
    logic            r_we;
    logic            r_ack;
    logic            r_err;
    logic [31:0]     r_dat;
    logic            r_csb;
    logic            r_web;
    logic [3:0]      r_wmask;
    logic [AW-1:0]   r_addr;
    logic [31:0]     r_din;
    logic            w_reject;
    logic            w_unused_bits;

`ifdef YCR_WB_SRAM_RANGE_CHK_EN
    // Out-of-range word, or a full-word access that is not word aligned.
    assign w_reject = ($unsigned(32'(wbd_adr_i[AW+1:2])) >= $unsigned(32'(MEM_DEPTH))) ||
                      ((wbd_adr_i[1:0] != 2'b00) && (wbd_sel_i == 4'hF));
    assign wbd_err_o = r_err;
`else
    assign w_reject  = 1'b0;
    assign wbd_err_o = 1'b0;
`endif

    assign w_unused_bits = &{1'b0, wbd_adr_i[31:AW+2], wbd_adr_i[1:0], r_err};

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 2'd0;
            r_we    <= 1'b0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_dat   <= 32'd0;
            r_csb   <= 1'b1;
            r_web   <= 1'b1;
            r_wmask <= 4'd0;
            r_addr  <= '0;
            r_din   <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (wbd_stb_i) begin
                        if (w_reject) begin
                            r_ack   <= 1'b1;
                            r_err   <= 1'b1;
                            r_state <= S_RESP;
                        end else begin
                            r_csb   <= 1'b0;
                            r_web   <= ~wbd_we_i;
                            r_wmask <= wbd_sel_i;
                            r_addr  <= wbd_adr_i[AW+1:2];
                            r_din   <= wbd_dat_i;
                            r_we    <= wbd_we_i;
                            r_state <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS: begin
                    r_csb <= 1'b1;
                    r_web <= 1'b1;
                    if (r_we) begin
                        r_ack   <= 1'b1;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt   <= 2'(RD_LAT - 1);
                        r_state <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    // Counter reaching zero means the macro output is valid this cycle.
                    if (r_cnt == 2'd0) begin
                        r_dat   <= mem_dout_i;
                        r_ack   <= 1'b1;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                S_RESP: begin
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_dat   <= 32'd0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign wbd_ack_o   = r_ack;
    assign wbd_dat_o   = r_dat;
    assign mem_csb_o   = r_csb;
    assign mem_web_o   = r_web;
    assign mem_wmask_o = r_wmask;
    assign mem_addr_o  = r_addr;
    assign mem_din_o   = r_din;

endmodule

`default_nettype wire
